jtag_dtm: RTL and testbench
===========================

Name: jtag_dtm

Overview:
- JTAG Debug Transport Module: the initiator end of the DMI. It turns external JTAG scans into DMI read/write requests to the Debug Module and returns read data and status through JTAG.
- JTAG pins are oversampled in the system clock domain; there is no TCK clock domain.
- Implements the RISC-V Debug Spec 1.0 DTM: TAP controller, 5-bit IR, IDCODE, BYPASS, DTMCS and DMI registers.

Parameters:
- ABITS, 7, DMI address width.
- IDCODE_VAL, 32'h1000_0001, value captured by IDCODE (bit 0 must be 1).
- IDLE_HINT, 1, value reported in dtmcs.idle.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  synchronous, active-high reset.
- iTck  in  1  async JTAG TCK; must satisfy f(TCK) ≤ f(iClk)/8.
- iTms  in  1  async JTAG TMS.
- iTdi  in  1  async JTAG TDI.
- oTdo  out  1  JTAG TDO.
- oTdoEn  out  1  high while the TAP is in Shift-IR or Shift-DR.
- oDmAddr  out  ABITS  DMI address.
- oDmWdata  out  32  DMI write data.
- iDmRdata  in  32  DMI read data; valid in the cycle where oDmAccessValid & oDmRead & iDmReady.
- oDmRead  out  1  DMI read request.
- oDmWrite  out  1  DMI write request.
- oDmAccessValid  out  1  DMI request valid.
- iDmReady  in  1  DM accepts the request this cycle; the current DM ties it high.

Behaviour:
- Reset (iRst high at posedge iClk):
  - TAP = Test-Logic-Reset; IR = 5'h01 (IDCODE).
  - Shift registers and stored DMI addr/data cleared; op status = 0; sticky error cleared; pending request cleared.
  - oTdo = 0, oTdoEn = 0, oDmAccessValid/oDmRead/oDmWrite = 0, oDmAddr = 0, oDmWdata = 0.
  - Asserting reset mid-access drops oDmAccessValid in the next cycle; the request is lost.
- Input sync and edge detect:
  - iTck, iTms and iTdi each pass through a 2-flop synchronizer; a third flop on TCK gives edge detect.
  - tck_rise = sync & ~prev; tck_fall = ~sync & prev.
  - Latency from pin TCK edge to the action is 3 iClk cycles.
- On tck_rise, using the CURRENT TAP state:
  - Capture-IR: IR shift register ← 5'b00001.
  - Shift-IR: shift right, TDI into the MSB.
  - Update-IR: IR ← IR shift register.
  - Capture-DR / Shift-DR / Update-DR: act on the register selected by IR (below).
  - The TAP then advances per the standard 16-state IEEE 1149.1 graph using sampled TMS. TMS=1 for 5 rises reaches Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset forces IR = IDCODE.
- On tck_fall: oTdo ← LSB of the active shift register in the Shift states, else holds; oTdoEn = state is Shift-IR or Shift-DR.
- IR decode (all other codes select BYPASS):
  - 0x01 IDCODE: 32b, capture IDCODE_VAL, no update.
  - 0x10 DTMCS: 32b.
    - Capture: {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=IDLE_HINT[2:0], dmistat[1:0], abits[5:0]=ABITS, version=4'd1}.
    - Update: bit16 = 1 clears the sticky error; bit17 = 1 clears sticky and pending, and drops oDmAccessValid.
  - 0x11 DMI: (ABITS+34)b, layout {addr, data[31:0], op[1:0]}.
    - Capture: {last_addr, last_rdata, op_status}. If a request is still pending at Capture, set sticky op_status = 3 (busy).
    - Update with op=1 (read) or op=2 (write), and op_status == 0 and no pending request: latch addr/data, set pending.
      - oDmAccessValid=1 with oDmRead=(op==1), oDmWrite=(op==2) from the next iClk cycle.
      - Held until iDmReady=1. In the ready cycle, a read latches iDmRdata into last_rdata; then clear valid/read/write and pending.
    - Update with op=0, op=3, or with sticky set: no DMI access. If pending at Update, set op_status = 3.
  - 0x00 and 0x1F BYPASS: 1b, captures 0.
- dmistat mirrors op_status.
  - op_status stays 0 or 3 only; op=2 (failed) is never generated.
  - op_status remains 3 until dmireset, dmihardreset, or iRst clears it.
- At most one DMI request is outstanding; oDmRead and oDmWrite are never both high.

Test Plan:
- Reset, then shift 32 DR bits with IR at default → TDO stream = 32'h1000_0001, LSB first; oTdoEn high only in Shift-DR.
- Load IR=0x1F, shift 8 bits 8'hA5 through DR → TDO = one-cycle-delayed copy, first bit 0.
- Load IR=0x10, capture/shift DTMCS → 32'h0000_1071.
- IR=0x11, scan {addr 7'h04, data 32'hDEADBEEF, op 2} → one write: oDmAccessValid & oDmWrite for exactly 1 cycle with iDmReady=1, addr 0x04, wdata DEADBEEF.
  - Then scan op=1 at addr 0x04 with iDmRdata=32'h12345678; the next scan captures data 12345678, op 0.
- Hold iDmReady=0, scan a read, then rescan → captured op=3; further writes are ignored.
  - Then DTMCS write with bit16=1 → dmistat=0; the next DMI scan works.
  - Repeat with bit17=1 while valid is held → valid drops, pending clears.
- Assert iRst for 1 cycle during an active read → all DMI outputs 0 next cycle, IR=0x01, op_status=0; 5 TCKs with TMS=1 from Shift-DR → Test-Logic-Reset.

Source files
------------

// File: rtl/jtag_dtm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : jtag_dtm
// Description : RISC-V JTAG Debug Transport Module with the JTAG pins
//               oversampled in iClk; issues DMI requests to the Debug Module.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_dtm #(
    parameter int          ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          IDLE_HINT  = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iTck,
    input  logic             iTms,
    input  logic             iTdi,
    output logic             oTdo,
    output logic             oTdoEn,
    output logic [ABITS-1:0] oDmAddr,
    output logic [31:0]      oDmWdata,
    input  logic [31:0]      iDmRdata,
    output logic             oDmRead,
    output logic             oDmWrite,
    output logic             oDmAccessValid,
    input  logic             iDmReady
);
    localparam int         c_DMI_W     = ABITS + 34;
    localparam logic [4:0] c_IR_IDCODE = 5'h01;
    localparam logic [4:0] c_IR_DTMCS  = 5'h10;
    localparam logic [4:0] c_IR_DMI    = 5'h11;
    localparam logic [2:0] c_IDLE      = 3'(IDLE_HINT);
    localparam logic [5:0] c_ABITS     = 6'(ABITS);

    typedef enum logic [3:0] {
        TLR      = 4'h0, RTI      = 4'h1, SEL_DR   = 4'h2, CAP_DR   = 4'h3,
        SHIFT_DR = 4'h4, EXIT1_DR = 4'h5, PAUSE_DR = 4'h6, EXIT2_DR = 4'h7,
        UPD_DR   = 4'h8, SEL_IR   = 4'h9, CAP_IR   = 4'hA, SHIFT_IR = 4'hB,
        EXIT1_IR = 4'hC, PAUSE_IR = 4'hD, EXIT2_IR = 4'hE, UPD_IR   = 4'hF
    } tap_state_t;

    tap_state_t         r_state, w_state_nxt;
    logic               r_tck_s1, r_tck_s2, r_tck_prev;
    logic               r_tms_s1, r_tms_s2, r_tdi_s1, r_tdi_s2;
    logic [4:0]         r_ir, r_ir_sr;
    logic [31:0]        r_dr32;
    logic [c_DMI_W-1:0] r_dmi_sr;
    logic               r_bypass;
    logic [ABITS-1:0]   r_addr;
    logic [31:0]        r_wdata, r_rdata;
    logic [1:0]         r_op_status;
    logic               r_dm_valid, r_dm_read, r_dm_write;
    logic               r_tdo, r_tdo_en;
    logic               w_tck_rise, w_tck_fall, w_dr_lsb, w_dmi_go;
    logic [1:0]         w_dmi_op;
    logic [31:0]        w_dtmcs;

    assign w_tck_rise = r_tck_s2 & ~r_tck_prev;
    assign w_tck_fall = ~r_tck_s2 & r_tck_prev;
    assign w_dtmcs    = {14'b0, 2'b00, 1'b0, c_IDLE, r_op_status, c_ABITS, 4'd1};
    assign w_dmi_op   = r_dmi_sr[1:0];
    assign w_dmi_go   = ((w_dmi_op == 2'd1) || (w_dmi_op == 2'd2))
                        && (r_op_status == 2'd0) && !r_dm_valid;

    assign oTdo           = r_tdo;
    assign oTdoEn         = r_tdo_en;
    assign oDmAddr        = r_addr;
    assign oDmWdata       = r_wdata;
    assign oDmRead        = r_dm_read;
    assign oDmWrite       = r_dm_write;
    assign oDmAccessValid = r_dm_valid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            {r_tck_s1, r_tck_s2, r_tck_prev} <= 3'b000;
            {r_tms_s1, r_tms_s2, r_tdi_s1, r_tdi_s2} <= 4'b0000;
        end else begin
            r_tck_s1   <= iTck;
            r_tck_s2   <= r_tck_s1;
            r_tck_prev <= r_tck_s2;
            r_tms_s1   <= iTms;
            r_tms_s2   <= r_tms_s1;
            r_tdi_s1   <= iTdi;
            r_tdi_s2   <= r_tdi_s1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= TLR;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_tck_rise) begin
            case (r_state)
                TLR:      w_state_nxt = r_tms_s2 ? TLR      : RTI;
                RTI:      w_state_nxt = r_tms_s2 ? SEL_DR   : RTI;
                SEL_DR:   w_state_nxt = r_tms_s2 ? SEL_IR   : CAP_DR;
                CAP_DR:   w_state_nxt = r_tms_s2 ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: w_state_nxt = r_tms_s2 ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: w_state_nxt = r_tms_s2 ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: w_state_nxt = r_tms_s2 ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: w_state_nxt = r_tms_s2 ? UPD_DR   : SHIFT_DR;
                UPD_DR:   w_state_nxt = r_tms_s2 ? SEL_DR   : RTI;
                SEL_IR:   w_state_nxt = r_tms_s2 ? TLR      : CAP_IR;
                CAP_IR:   w_state_nxt = r_tms_s2 ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: w_state_nxt = r_tms_s2 ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: w_state_nxt = r_tms_s2 ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: w_state_nxt = r_tms_s2 ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: w_state_nxt = r_tms_s2 ? UPD_IR   : SHIFT_IR;
                UPD_IR:   w_state_nxt = r_tms_s2 ? SEL_DR   : RTI;
                default:  w_state_nxt = TLR;
            endcase
        end
    end

    always_comb begin
        case (r_ir)
            c_IR_IDCODE, c_IR_DTMCS: w_dr_lsb = r_dr32[0];
            c_IR_DMI:                w_dr_lsb = r_dmi_sr[0];
            default:                 w_dr_lsb = r_bypass;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ir        <= c_IR_IDCODE;
            r_ir_sr     <= 5'd0;
            r_dr32      <= 32'd0;
            r_dmi_sr    <= '0;
            r_bypass    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_op_status <= 2'd0;
            r_dm_valid  <= 1'b0;
            r_dm_read   <= 1'b0;
            r_dm_write  <= 1'b0;
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
        end else begin
            if (r_dm_valid && iDmReady) begin
                if (r_dm_read) r_rdata <= iDmRdata;
                r_dm_valid <= 1'b0;
                r_dm_read  <= 1'b0;
                r_dm_write <= 1'b0;
            end
            if (w_tck_rise) begin
                case (r_state)
                    CAP_IR:   r_ir_sr <= 5'b00001;
                    SHIFT_IR: r_ir_sr <= {r_tdi_s2, r_ir_sr[4:1]};
                    UPD_IR:   r_ir    <= r_ir_sr;
                    CAP_DR: begin
                        case (r_ir)
                            c_IR_IDCODE: r_dr32 <= IDCODE_VAL;
                            c_IR_DTMCS:  r_dr32 <= w_dtmcs;
                            c_IR_DMI: begin
                                // A still-pending request is reported as busy right away
                                r_dmi_sr <= {r_addr, r_rdata, (r_dm_valid ? 2'd3 : r_op_status)};
                                if (r_dm_valid) r_op_status <= 2'd3;
                            end
                            default:     r_bypass <= 1'b0;
                        endcase
                    end
                    SHIFT_DR: begin
                        case (r_ir)
                            c_IR_IDCODE, c_IR_DTMCS: r_dr32 <= {r_tdi_s2, r_dr32[31:1]};
                            c_IR_DMI: r_dmi_sr <= {r_tdi_s2, r_dmi_sr[c_DMI_W-1:1]};
                            default:  r_bypass <= r_tdi_s2;
                        endcase
                    end
                    UPD_DR: begin
                        if (r_ir == c_IR_DTMCS) begin
                            if (r_dr32[17]) begin
                                r_op_status <= 2'd0;
                                r_dm_valid  <= 1'b0;
                                r_dm_read   <= 1'b0;
                                r_dm_write  <= 1'b0;
                            end else if (r_dr32[16]) begin
                                r_op_status <= 2'd0;
                            end
                        end else if (r_ir == c_IR_DMI) begin
                            if (w_dmi_go) begin
                                r_addr     <= r_dmi_sr[c_DMI_W-1:34];
                                r_wdata    <= r_dmi_sr[33:2];
                                r_dm_valid <= 1'b1;
                                r_dm_read  <= (w_dmi_op == 2'd1);
                                r_dm_write <= (w_dmi_op == 2'd2);
                            end else if (r_dm_valid) begin
                                r_op_status <= 2'd3;
                            end
                        end
                    end
                    default: ;
                endcase
                if (w_state_nxt == TLR) r_ir <= c_IR_IDCODE;
            end
            if (w_tck_fall) begin
                if (r_state == SHIFT_IR)      r_tdo <= r_ir_sr[0];
                else if (r_state == SHIFT_DR) r_tdo <= w_dr_lsb;
                r_tdo_en <= (r_state == SHIFT_IR) || (r_state == SHIFT_DR);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jtag_dtm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_jtag_dtm
// Description : Directed vector bench for jtag_dtm driving bit-banged JTAG.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_dtm;
    localparam int HALF = 50;

    logic        iClk = 1'b0;
    logic        iRst, iTck, iTms, iTdi;
    logic        oTdo, oTdoEn;
    logic [6:0]  oDmAddr;
    logic [31:0] oDmWdata, iDmRdata;
    logic        oDmRead, oDmWrite, oDmAccessValid, iDmReady;

    int          total = 0, bad = 0;
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [6:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        last_tdo, last_en;

    typedef struct {
        logic        load_ir;
        logic [4:0]  ir;
        int          n;
        logic [63:0] din;
        logic [63:0] exp;
        int          exp_wr;
        int          exp_rd;
    } vec_t;
    vec_t tbl[6];

    jtag_dtm dut (
        .iClk(iClk), .iRst(iRst), .iTck(iTck), .iTms(iTms), .iTdi(iTdi),
        .oTdo(oTdo), .oTdoEn(oTdoEn), .oDmAddr(oDmAddr), .oDmWdata(oDmWdata),
        .iDmRdata(iDmRdata), .oDmRead(oDmRead), .oDmWrite(oDmWrite),
        .oDmAccessValid(oDmAccessValid), .iDmReady(iDmReady)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) begin
        if (oDmAccessValid && oDmWrite) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= oDmAddr;
            wr_data <= oDmWdata;
        end
        if (oDmAccessValid && oDmRead && iDmReady) rd_cnt <= rd_cnt + 1;
        if (oDmRead && oDmWrite) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCK period; TDO/TDOEN are sampled just before the rising edge.
    task automatic tck(input logic tms, input logic tdi);
        iTms = tms;
        iTdi = tdi;
        #HALF;
        last_tdo = oTdo;
        last_en  = oTdoEn;
        iTck = 1'b1;
        #HALF;
        iTck = 1'b0;
    endtask

    task automatic shift_ir(input logic [4:0] val, output logic [4:0] irout);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, val[i]);
            irout[i] = last_tdo;
        end
        tck(1, 0); tck(0, 0);
        #100;
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic en_shift, output logic en_other);
        dout = '0; en_shift = 1'b1; en_other = 1'b0;
        tck(1, 0); tck(0, 0);
        tck(0, 0); en_other |= last_en;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i]);
            dout[i] = last_tdo;
            en_shift &= last_en;
        end
        tck(1, 0); en_other |= last_en;
        tck(0, 0); en_other |= last_en;
        #100;
    endtask

    initial begin
        logic [63:0] dout;
        logic [4:0]  irout;
        logic        es, eo;
        int          w0, r0;

        iRst = 1'b1; iTck = 1'b0; iTms = 1'b1; iTdi = 1'b0;
        iDmRdata = 32'h1234_5678; iDmReady = 1'b1;

        tbl[0] = '{1'b0, 5'h01, 32, 64'h0, 64'h1000_0001, 0, 0};
        tbl[1] = '{1'b1, 5'h1F, 8, 64'hA5, 64'h4A, 0, 0};
        tbl[2] = '{1'b1, 5'h10, 32, 64'h0, 64'h1071, 0, 0};
        tbl[3] = '{1'b1, 5'h11, 41, 64'({7'h04, 32'hDEAD_BEEF, 2'd2}), 64'h0, 1, 0};
        tbl[4] = '{1'b0, 5'h11, 41, 64'({7'h04, 32'h0, 2'd1}), 64'({7'h04, 32'h0, 2'd0}), 0, 1};
        tbl[5] = '{1'b0, 5'h11, 41, 64'h0, 64'({7'h04, 32'h1234_5678, 2'd0}), 0, 0};

        #100;
        chk("reset_ctl", 64'({oTdo, oTdoEn, oDmAccessValid, oDmRead, oDmWrite}), 64'h0);
        chk("reset_addr", 64'(oDmAddr), 64'h0);
        chk("reset_wdata", 64'(oDmWdata), 64'h0);
        iRst = 1'b0;
        tck(0, 0);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].load_ir) shift_ir(tbl[i].ir, irout);
            w0 = wr_cnt; r0 = rd_cnt;
            scan_dr(tbl[i].n, tbl[i].din, dout, es, eo);
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].exp);
            chk($sformatf("vec%0d_tdoen", i), 64'({es, eo}), 64'h2);
            chk($sformatf("vec%0d_writes", i), 64'(wr_cnt - w0), 64'(tbl[i].exp_wr));
            chk($sformatf("vec%0d_reads", i), 64'(rd_cnt - r0), 64'(tbl[i].exp_rd));
        end
        chk("write_addr", 64'(wr_addr), 64'h04);
        chk("write_data", 64'(wr_data), 64'hDEAD_BEEF);

        // Busy: request held off by the DM, rescans report op=3 and are ignored
        iDmReady = 1'b0; iDmRdata = 32'hA5A5_0000;
        scan_dr(41, 64'({7'h05, 32'h0, 2'd1}), dout, es, eo);
        chk("busy_cap0", dout, 64'({7'h04, 32'h1234_5678, 2'd0}));
        chk("busy_held", 64'({oDmAccessValid, oDmRead, oDmWrite}), 64'h6);
        scan_dr(41, 64'({7'h06, 32'h1111_1111, 2'd2}), dout, es, eo);
        chk("busy_cap1", dout, 64'({7'h05, 32'h1234_5678, 2'd3}));
        w0 = wr_cnt;
        scan_dr(41, 64'({7'h06, 32'h1111_1111, 2'd2}), dout, es, eo);
        chk("busy_cap2", dout, 64'({7'h05, 32'h1234_5678, 2'd3}));
        chk("busy_no_write", 64'(wr_cnt - w0), 64'h0);
        chk("busy_addr", 64'(oDmAddr), 64'h05);

        shift_ir(5'h10, irout);
        scan_dr(32, 64'h1_0000, dout, es, eo);
        chk("dtmcs_busy", dout, 64'h1C71);
        iDmReady = 1'b1;
        #100;
        chk("busy_done", 64'(oDmAccessValid), 64'h0);
        scan_dr(32, 64'h0, dout, es, eo);
        chk("dtmcs_cleared", dout, 64'h1071);
        shift_ir(5'h11, irout);
        w0 = wr_cnt;
        scan_dr(41, 64'({7'h08, 32'hCAFE_F00D, 2'd2}), dout, es, eo);
        chk("after_reset_cap", dout, 64'({7'h05, 32'hA5A5_0000, 2'd0}));
        chk("after_reset_wr", 64'(wr_cnt - w0), 64'h1);
        chk("after_reset_wdata", 64'({wr_addr, wr_data}), 64'({7'h08, 32'hCAFE_F00D}));

        // dmihardreset while a request is held
        iDmReady = 1'b0;
        scan_dr(41, 64'({7'h09, 32'h0, 2'd1}), dout, es, eo);
        chk("hard_cap0", dout, 64'({7'h08, 32'hA5A5_0000, 2'd0}));
        chk("hard_held", 64'(oDmAccessValid), 64'h1);
        shift_ir(5'h10, irout);
        scan_dr(32, 64'h2_0000, dout, es, eo);
        chk("hard_dtmcs", dout, 64'h1071);
        chk("hard_dropped", 64'({oDmAccessValid, oDmRead, oDmWrite}), 64'h0);
        shift_ir(5'h11, irout);
        scan_dr(41, 64'h0, dout, es, eo);
        chk("hard_cap1", dout, 64'({7'h09, 32'hA5A5_0000, 2'd0}));

        // Reset during an active read
        scan_dr(41, 64'({7'h0A, 32'h5555_AAAA, 2'd1}), dout, es, eo);
        chk("rst_read_held", 64'({oDmAccessValid, oDmRead, oDmWdata}), 64'({2'b11, 32'h5555_AAAA}));
        iRst = 1'b1;
        #10;
        iRst = 1'b0;
        chk("rst_dmi_outs", 64'({oDmAccessValid, oDmRead, oDmWrite, oDmAddr, oDmWdata}), 64'h0);
        tck(0, 0);
        scan_dr(32, 64'h0, dout, es, eo);
        chk("rst_idcode", dout, 64'h1000_0001);
        shift_ir(5'h10, irout);
        chk("ir_capture", 64'(irout), 64'h01);
        scan_dr(32, 64'h0, dout, es, eo);
        chk("rst_dtmcs", dout, 64'h1071);

        // Five TMS=1 clocks from Shift-DR reach Test-Logic-Reset and restore IDCODE
        shift_ir(5'h1F, irout);
        tck(1, 0); tck(0, 0); tck(0, 0);
        #HALF;
        chk("in_shift_dr_en", 64'(oTdoEn), 64'h1);
        for (int i = 0; i < 5; i++) tck(1, 0);
        tck(0, 0);
        #HALF;
        chk("tlr_en", 64'(oTdoEn), 64'h0);
        scan_dr(32, 64'h0, dout, es, eo);
        chk("tlr_idcode", dout, 64'h1000_0001);
        chk("never_rd_and_wr", 64'(both_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
